// File: rtl/tff_cell.sv
// T flip-flop: the stored bit inverts on each rising clk edge while t is high.
// The asynchronous active-high reset clears it to 0.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 1'b0;
        else
            q <= q ^ t;
    end

endmodule

// File: rtl/count_down_4bit.sv
// 4-bit down counter built from T flip-flops, with parallel load, zero flag and borrow-out.
// The borrow-out can drive the enable of a second counter to form an 8-bit counter.
module count_down_4bit #(
    parameter bit STOP_AT_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       zero,
    output logic       bout
);

    wire [3:0] nq;
    wire [3:0] ct_raw;
    wire [3:0] ct;
    wire [3:0] lt;
    wire [3:0] t;
    wire       nz;
    wire       nload;
    wire       n01;
    wire       n012;

    not u_nq0 (nq[0], q[0]);
    not u_nq1 (nq[1], q[1]);
    not u_nq2 (nq[2], q[2]);
    not u_nq3 (nq[3], q[3]);

    // A bit toggles while counting down only when every lower bit is 0.
    assign ct_raw[0] = en;
    and u_n01  (n01, nq[0], nq[1]);
    and u_n012 (n012, n01, nq[2]);
    and u_ct1  (ct_raw[1], en, nq[0]);
    and u_ct2  (ct_raw[2], en, n01);
    and u_ct3  (ct_raw[3], en, n012);

    and u_zero (zero, n012, nq[3]);
    not u_nz   (nz, zero);
    not u_nld  (nload, load);
    and u_bout (bout, en, zero, nload);

    // In hold-at-zero mode the count toggles are blocked while q is 0.
    generate
        if (STOP_AT_ZERO) begin : g_stop
            and u_g0 (ct[0], ct_raw[0], nz);
            and u_g1 (ct[1], ct_raw[1], nz);
            and u_g2 (ct[2], ct_raw[2], nz);
            and u_g3 (ct[3], ct_raw[3], nz);
        end else begin : g_wrap
            assign ct = ct_raw;
        end
    endgenerate

    xor u_lt0 (lt[0], q[0], d[0]);
    xor u_lt1 (lt[1], q[1], d[1]);
    xor u_lt2 (lt[2], q[2], d[2]);
    xor u_lt3 (lt[3], q[3], d[3]);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            assign t[i] = load ? lt[i] : ct[i];
            tff_cell u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (t[i]),
                .q     (q[i])
            );
        end
    endgenerate

endmodule
